// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage load/store unit: memory opcodes,
// exception codes and the access FSM states.
package mem_access_unit_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd9,
    MEM_SH   = 4'd10,
    MEM_SW   = 4'd11
  } memop_e;

  typedef enum logic [1:0] {
    EXC_NONE = 2'b00,
    EXC_ADEL = 2'b01,
    EXC_ADES = 2'b10,
    EXC_BUS  = 2'b11
  } exc_code_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mau_state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// EX-side handshake, data-memory port, write-back and exception signals of
// the load/store unit, bundled with unit-side (master) and environment (slave) views.
interface mem_access_unit_if;

  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_memop;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        exc_valid;
  logic [1:0]  exc_code;
  logic [31:0] exc_badvaddr;

  modport master (
    input  ex_valid, ex_memop, ex_addr, ex_wdata, ex_rd, dm_ack, dm_rdata,
    output ex_ready, dm_req, dm_we, dm_addr, dm_be, dm_wdata,
           wb_valid, wb_rd, wb_data, exc_valid, exc_code, exc_badvaddr
  );

  modport slave (
    output ex_valid, ex_memop, ex_addr, ex_wdata, ex_rd, dm_ack, dm_rdata,
    input  ex_ready, dm_req, dm_we, dm_addr, dm_be, dm_wdata,
           wb_valid, wb_rd, wb_data, exc_valid, exc_code, exc_badvaddr
  );

endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Combinational byte-lane logic: byte enables, replicated store data,
// extended load data and alignment check for one memop/address pair.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [3:0]  i_memop,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata,
  output logic        o_is_load,
  output logic        o_is_store,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_be       = '0;
    o_wdata    = '0;
    o_ldata    = '0;
    o_is_load  = 1'b0;
    o_is_store = 1'b0;
    o_misalign = 1'b0;
    case (i_memop)
      MEM_LB: begin
        o_is_load = 1'b1;
        o_be      = 4'b0001 << i_addr_lo;
        o_ldata   = {{24{w_byte[7]}}, w_byte};
      end
      MEM_LBU: begin
        o_is_load = 1'b1;
        o_be      = 4'b0001 << i_addr_lo;
        o_ldata   = {24'd0, w_byte};
      end
      MEM_LH: begin
        o_is_load  = 1'b1;
        o_misalign = i_addr_lo[0];
        o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_ldata    = {{16{w_half[15]}}, w_half};
      end
      MEM_LHU: begin
        o_is_load  = 1'b1;
        o_misalign = i_addr_lo[0];
        o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_ldata    = {16'd0, w_half};
      end
      MEM_LW: begin
        o_is_load  = 1'b1;
        o_misalign = |i_addr_lo;
        o_be       = '1;
        o_ldata    = i_rdata;
      end
      MEM_SB: begin
        o_is_store = 1'b1;
        o_be       = 4'b0001 << i_addr_lo;
        o_wdata    = {4{i_wdata[7:0]}};
      end
      MEM_SH: begin
        o_is_store = 1'b1;
        o_misalign = i_addr_lo[0];
        o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_wdata[15:0]}};
      end
      MEM_SW: begin
        o_is_store = 1'b1;
        o_misalign = |i_addr_lo;
        o_be       = '1;
        o_wdata    = i_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: alignment check, req/ack data-memory access
// with optional timeout, and extended load write-back.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic               clk,
  input logic               rstn,
  mem_access_unit_if.master bus
);

  localparam int unsigned CNT_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TMO_LAST   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TMO_LAST_C = CNT_W'(TMO_LAST);
  localparam logic        TMO_EN     = (TIMEOUT_CYCLES > 0);

  mau_state_e  r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]  r_op;
  logic [31:0] r_addr;
  logic [4:0]  r_rd;

  logic        r_dm_req;
  logic        r_dm_we;
  logic [31:0] r_dm_addr;
  logic [3:0]  r_dm_be;
  logic [31:0] r_dm_wdata;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_exc_valid;
  exc_code_e   r_exc_code;
  logic [31:0] r_exc_badvaddr;

  logic [3:0]  w_op;
  logic [1:0]  w_addr_lo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_misalign;
  logic        w_timeout;

  // One lane aligner serves both phases: EX inputs while idle, the latched op during access.
  assign w_op      = (r_state == ST_IDLE) ? bus.ex_memop    : r_op;
  assign w_addr_lo = (r_state == ST_IDLE) ? bus.ex_addr[1:0] : r_addr[1:0];
  assign w_timeout = TMO_EN && (r_cnt == TMO_LAST_C);

  mem_lane_align u_align (
    .i_memop    (w_op),
    .i_addr_lo  (w_addr_lo),
    .i_wdata    (bus.ex_wdata),
    .i_rdata    (bus.dm_rdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_ldata    (w_ldata),
    .o_is_load  (w_is_load),
    .o_is_store (w_is_store),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_op           <= '0;
      r_addr         <= '0;
      r_rd           <= '0;
      r_dm_req       <= 1'b0;
      r_dm_we        <= 1'b0;
      r_dm_addr      <= '0;
      r_dm_be        <= '0;
      r_dm_wdata     <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_data      <= '0;
      r_exc_valid    <= 1'b0;
      r_exc_code     <= EXC_NONE;
      r_exc_badvaddr <= '0;
    end else begin
      r_wb_valid  <= 1'b0;
      r_exc_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.ex_valid) begin
            if (w_misalign) begin
              r_exc_valid    <= 1'b1;
              r_exc_code     <= w_is_store ? EXC_ADES : EXC_ADEL;
              r_exc_badvaddr <= bus.ex_addr;
            end else if (w_is_load || w_is_store) begin
              r_state    <= ST_ACCESS;
              r_cnt      <= '0;
              r_op       <= bus.ex_memop;
              r_addr     <= bus.ex_addr;
              r_rd       <= bus.ex_rd;
              r_dm_req   <= 1'b1;
              r_dm_we    <= w_is_store;
              r_dm_addr  <= {bus.ex_addr[31:2], 2'b00};
              r_dm_be    <= w_be;
              r_dm_wdata <= w_wdata;
            end
          end
        end
        ST_ACCESS: begin
          // An ack on the timeout edge still completes the access normally.
          if (bus.dm_ack) begin
            r_state  <= ST_IDLE;
            r_dm_req <= 1'b0;
            if (w_is_load) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_rd;
              r_wb_data  <= w_ldata;
            end
          end else if (w_timeout) begin
            r_state        <= ST_IDLE;
            r_dm_req       <= 1'b0;
            r_exc_valid    <= 1'b1;
            r_exc_code     <= EXC_BUS;
            r_exc_badvaddr <= r_addr;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ex_ready     = (r_state == ST_IDLE);
  assign bus.dm_req       = r_dm_req;
  assign bus.dm_we        = r_dm_we;
  assign bus.dm_addr      = r_dm_addr;
  assign bus.dm_be        = r_dm_be;
  assign bus.dm_wdata     = r_dm_wdata;
  assign bus.wb_valid     = r_wb_valid;
  assign bus.wb_rd        = r_wb_rd;
  assign bus.wb_data      = r_wb_data;
  assign bus.exc_valid    = r_exc_valid;
  assign bus.exc_code     = r_exc_code;
  assign bus.exc_badvaddr = r_exc_badvaddr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed cases plus random ops against
// an arithmetic reference model, with a scripted memory responder.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int unsigned TMO = 4;

  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; int start; int len; } req_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; int cyc; } wb_t;
  typedef struct { logic [1:0] code; logic [31:0] vaddr; int cyc; } exc_t;
  typedef struct { int unsigned dly; logic [31:0] rdata; } rsp_t;

  logic clk;
  logic rstn;
  int   cyc;
  int   checks;
  int   errors;

  req_t exp_req[$];
  wb_t  exp_wb[$];
  exc_t exp_exc[$];
  rsp_t resp_q[$];

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned op_bytes(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd9:  return 1;
      4'd2, 4'd5, 4'd10: return 2;
      4'd3, 4'd11:       return 4;
      default:           return 0;
    endcase
  endfunction

  function automatic bit op_is_store(input logic [3:0] op);
    return (op == 4'd9) || (op == 4'd10) || (op == 4'd11);
  endfunction

  function automatic logic [3:0] model_be(input logic [3:0] op, input logic [31:0] addr);
    int unsigned m;
    m = ((32'd1 << op_bytes(op)) - 32'd1) << (addr % 32'd4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [3:0] op, input logic [31:0] wd);
    case (op_bytes(op))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rd);
    int unsigned n;
    logic [31:0] mask, v;
    n    = op_bytes(op);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v    = (rd >> (8 * (addr % 32'd4))) & mask;
    if ((op == 4'd1 || op == 4'd2) && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, input int unsigned dly, input logic [31:0] rdat);
    int unsigned waitc;
    int e0;
    int unsigned n;
    waitc        = 0;
    bus.ex_valid = 1'b1;
    bus.ex_memop = op;
    bus.ex_addr  = addr;
    bus.ex_wdata = wd;
    bus.ex_rd    = rd;
    @(negedge clk);
    while (!bus.ex_ready && waitc < 64) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.ex_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_wait: ex_ready stuck low, required 1 within 64 cycles");
      bus.ex_valid = 1'b0;
      return;
    end
    e0 = cyc + 1;
    n  = op_bytes(op);
    if (n != 0) begin
      if ((addr % 32'(n)) != 0) begin
        exp_exc.push_back('{code: op_is_store(op) ? 2'b10 : 2'b01, vaddr: addr, cyc: e0});
      end else begin
        exp_req.push_back('{we: op_is_store(op), addr: addr & 32'hFFFF_FFFC, be: model_be(op, addr),
                            wdata: model_wdata(op, wd), start: e0,
                            len: (dly >= TMO) ? int'(TMO) : int'(dly) + 1});
        resp_q.push_back('{dly: dly, rdata: rdat});
        if (dly >= TMO)
          exp_exc.push_back('{code: 2'b11, vaddr: addr, cyc: e0 + int'(TMO)});
        else if (!op_is_store(op))
          exp_wb.push_back('{rd: rd, data: model_load(op, addr, rdat), cyc: e0 + 1 + int'(dly)});
      end
    end
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
    bus.ex_memop = 4'($urandom_range(0, 15));
    bus.ex_addr  = $urandom();
    bus.ex_wdata = $urandom();
  endtask

  // ---------------- memory responder ----------------
  int unsigned rsp_cnt;
  rsp_t        cur_rsp;

  initial begin
    bus.dm_ack   = 1'b0;
    bus.dm_rdata = '0;
    rsp_cnt      = 0;
    cur_rsp      = '{dly: 99, rdata: 32'd0};
    forever begin
      @(negedge clk);
      if (bus.dm_req && rstn) begin
        if (rsp_cnt == 0) begin
          if (resp_q.size() > 0) cur_rsp = resp_q.pop_front();
          else cur_rsp = '{dly: 99, rdata: 32'd0};
        end
        bus.dm_ack   = (rsp_cnt == cur_rsp.dly);
        bus.dm_rdata = bus.dm_ack ? cur_rsp.rdata : $urandom();
        rsp_cnt++;
      end else begin
        // stray acks while no request is outstanding must be ignored
        rsp_cnt      = 0;
        bus.dm_ack   = ($urandom_range(0, 3) == 0);
        bus.dm_rdata = $urandom();
      end
    end
  end

  // ---------------- monitor ----------------
  bit   mon_in_req;
  int   mon_len;
  req_t mon_cur;

  initial mon_in_req = 1'b0;

  always @(negedge clk) begin
    if (!rstn) begin
      mon_in_req = 1'b0;
    end else begin
      if (bus.wb_valid && bus.exc_valid) begin
        checks++;
        errors++;
        $display("FAIL wb_exc_overlap: wb_valid and exc_valid both 1, required exclusive");
      end
      if (bus.dm_req) begin
        if (!mon_in_req) begin
          if (exp_req.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: dm_req=1 addr 0x%08h, required no request", bus.dm_addr);
            mon_cur = '{we: bus.dm_we, addr: bus.dm_addr, be: bus.dm_be, wdata: bus.dm_wdata, start: cyc, len: 0};
          end else begin
            mon_cur = exp_req.pop_front();
            chk("req_start", 32'(cyc), 32'(mon_cur.start));
          end
          mon_in_req = 1'b1;
          mon_len    = 0;
        end
        chk("dm_we", 32'(bus.dm_we), 32'(mon_cur.we));
        chk("dm_addr", bus.dm_addr, mon_cur.addr);
        chk("dm_be", 32'(bus.dm_be), 32'(mon_cur.be));
        if (mon_cur.we) chk("dm_wdata", bus.dm_wdata, mon_cur.wdata);
        mon_len++;
      end else if (mon_in_req) begin
        if (mon_cur.len != 0) chk("req_len", 32'(mon_len), 32'(mon_cur.len));
        mon_in_req = 1'b0;
      end
      if (bus.wb_valid) begin
        if (exp_wb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wb: wb_valid=1 data 0x%08h, required no write-back", bus.wb_data);
        end else begin
          wb_t w;
          w = exp_wb.pop_front();
          chk("wb_cycle", 32'(cyc), 32'(w.cyc));
          chk("wb_rd", 32'(bus.wb_rd), 32'(w.rd));
          chk("wb_data", bus.wb_data, w.data);
        end
      end
      if (bus.exc_valid) begin
        if (exp_exc.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_exc: exc_valid=1 code %0d, required no exception", bus.exc_code);
        end else begin
          exc_t x;
          x = exp_exc.pop_front();
          chk("exc_cycle", 32'(cyc), 32'(x.cyc));
          chk("exc_code", 32'(bus.exc_code), 32'(x.code));
          chk("exc_badvaddr", bus.exc_badvaddr, x.vaddr);
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_ex_ready"}, 32'(bus.ex_ready), 32'd1);
    chk({tag, "_dm_req"}, 32'(bus.dm_req), 32'd0);
    chk({tag, "_dm_we"}, 32'(bus.dm_we), 32'd0);
    chk({tag, "_dm_be"}, 32'(bus.dm_be), 32'd0);
    chk({tag, "_dm_addr"}, bus.dm_addr, 32'd0);
    chk({tag, "_dm_wdata"}, bus.dm_wdata, 32'd0);
    chk({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd0);
    chk({tag, "_wb_data"}, bus.wb_data, 32'd0);
    chk({tag, "_exc_valid"}, 32'(bus.exc_valid), 32'd0);
    chk({tag, "_exc_code"}, 32'(bus.exc_code), 32'd0);
    chk({tag, "_exc_badvaddr"}, bus.exc_badvaddr, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  logic [3:0] op_tab [9];

  initial begin
    logic [3:0]  op;
    logic [31:0] addr;
    int unsigned dly;
    checks = 0;
    errors = 0;
    op_tab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11};
    rstn         = 1'b0;
    bus.ex_valid = 1'b0;
    bus.ex_memop = '0;
    bus.ex_addr  = '0;
    bus.ex_wdata = '0;
    bus.ex_rd    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // directed cases
    issue(MEM_LW,   32'h0000_0100, 32'h0,          5'd3,  0, 32'hDEAD_BEEF);
    issue(MEM_LB,   32'h0000_0103, 32'h0,          5'd4,  1, 32'h8011_2233);
    issue(MEM_LBU,  32'h0000_0103, 32'h0,          5'd5,  0, 32'h8011_2233);
    issue(MEM_LHU,  32'h0000_0102, 32'h0,          5'd6,  2, 32'h8011_2233);
    issue(MEM_LH,   32'h0000_0102, 32'h0,          5'd7,  0, 32'h8011_2233);
    issue(MEM_SB,   32'h0000_0101, 32'h1234_5678,  5'd0,  0, 32'h0);
    issue(MEM_SH,   32'h0000_0102, 32'h1234_5678,  5'd0,  1, 32'h0);
    issue(MEM_SW,   32'h0000_0104, 32'hA5A5_0F0F,  5'd0,  0, 32'h0);
    issue(MEM_LW,   32'h0000_0102, 32'h0,          5'd8,  0, 32'h0);
    issue(MEM_SH,   32'h0000_0201, 32'h0,          5'd0,  0, 32'h0);
    issue(MEM_NONE, 32'h0000_0301, 32'h0,          5'd9,  0, 32'h0);
    issue(MEM_LW,   32'h0000_0400, 32'h0,          5'd10, 9, 32'h0);
    issue(MEM_LW,   32'h0000_0404, 32'h0,          5'd11, TMO - 1, 32'h1357_9BDF);
    issue(MEM_SW,   32'h0000_0408, 32'h0000_0001,  5'd0,  9, 32'h0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      op   = op_tab[$urandom_range(0, 8)];
      addr = $urandom();
      if ($urandom_range(0, 2) != 0) addr = addr & 32'hFFFF_FFFC | 32'($urandom_range(0, 1)) * 32'd2;
      dly  = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO, TMO + 2) : $urandom_range(0, TMO - 1);
      issue(op, addr, $urandom(), 5'($urandom_range(0, 31)), dly, $urandom());
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    // reset while an access is outstanding
    issue(MEM_LW, 32'h0000_0300, 32'h0, 5'd12, 9, 32'h0);
    @(posedge clk);
    #2;
    chk("midrst_req_before", 32'(bus.dm_req), 32'd1);
    rstn = 1'b0;
    #1;
    chk("midrst_dm_req", 32'(bus.dm_req), 32'd0);
    chk("midrst_ex_ready", 32'(bus.ex_ready), 32'd1);
    exp_req.delete();
    exp_wb.delete();
    exp_exc.delete();
    resp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    check_reset_state("midrst");
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    issue(MEM_LW, 32'h0000_0304, 32'h0, 5'd13, 0, 32'hCAFE_F00D);
    issue(MEM_LB, 32'h0000_0305, 32'h0, 5'd14, 1, 32'h0000_F100);

    for (int i = 0; i < 100; i++) begin
      if (exp_req.size() == 0 && exp_wb.size() == 0 && exp_exc.size() == 0 && !mon_in_req) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("drain_outstanding", 32'(exp_req.size() + exp_wb.size() + exp_exc.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
